// File: rtl/secure_key_reader.sv
// Fetches a KEY_W-bit key word by word over a req/ack port and releases it only once complete and error-free.
// Latency: registered outputs; one REQ cycle plus one GAP cycle per word, key_valid one cycle after the last ack.
// Backpressure: the store stalls by withholding rd_ack for up to TIMEOUT cycles per word; longer stalls abort the fetch.
module secure_key_reader #(
    parameter int KEY_W   = 128,
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 16,
    localparam int NWORDS = KEY_W / WORD_W,
    localparam int AW     = (NWORDS > 1) ? $clog2(NWORDS) : 1,
    localparam int CW     = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_start_i,
    input  logic              key_clear_i,
    output logic              rd_req_o,
    output logic [AW-1:0]     rd_addr_o,
    input  logic              rd_ack_i,
    input  logic [WORD_W-1:0] rd_data_i,
    input  logic              rd_err_i,
    output logic [KEY_W-1:0]  key_out_o,
    output logic              key_valid_o,
    output logic              busy_o,
    output logic              fetch_err_o
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_GAP  = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [KEY_W-1:0] shadow_q, shadow_d;

    logic              rd_req_q;
    logic [AW-1:0]     rd_addr_q;
    logic [KEY_W-1:0]  key_out_q;
    logic              key_valid_q;
    logic              busy_q;
    logic              fetch_err_q;

    logic restart_ok;
    assign restart_ok = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);

    // Next-state logic: commands first (clear beats start), then the fetch sequencer.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        if (key_clear_i) begin
            state_d  = S_IDLE;
            idx_d    = '0;
            cnt_d    = '0;
            shadow_d = '0;
        end else if (fetch_start_i && restart_ok) begin
            // Any previously held key is wiped before the new fetch begins.
            state_d  = S_REQ;
            idx_d    = '0;
            cnt_d    = '0;
            shadow_d = '0;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (rd_err_i) begin
                        // Error wins over a same-cycle ack; nothing partial survives.
                        state_d  = S_ERR;
                        cnt_d    = '0;
                        shadow_d = '0;
                    end else if (rd_ack_i) begin
                        shadow_d[int'(idx_q)*WORD_W +: WORD_W] = rd_data_i;
                        cnt_d = '0;
                        if (idx_q == AW'(NWORDS - 1)) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + AW'(1);
                            state_d = S_GAP;
                        end
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        state_d  = S_ERR;
                        cnt_d    = '0;
                        shadow_d = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_GAP: begin
                    // Single idle cycle so every word gets a fresh request edge.
                    state_d = S_REQ;
                    cnt_d   = '0;
                end
                default: begin
                    // IDLE/DONE/ERR hold; stray acks and errors are ignored here.
                end
            endcase
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
        end
    end

    // Output registers decoded from the next state; key_out is gated so a partial key never leaves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_req_q    <= 1'b0;
            rd_addr_q   <= '0;
            key_out_q   <= '0;
            key_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            rd_req_q    <= (state_d == S_REQ);
            rd_addr_q   <= (state_d == S_REQ) ? idx_d : '0;
            key_out_q   <= (state_d == S_DONE) ? shadow_d : '0;
            key_valid_q <= (state_d == S_DONE);
            busy_q      <= (state_d == S_REQ) || (state_d == S_GAP);
            fetch_err_q <= (state_d == S_ERR);
        end
    end

    assign rd_req_o    = rd_req_q;
    assign rd_addr_o   = rd_addr_q;
    assign key_out_o   = key_out_q;
    assign key_valid_o = key_valid_q;
    assign busy_o      = busy_q;
    assign fetch_err_o = fetch_err_q;

endmodule

// File: tb/tb_secure_key_reader.sv
// Randomised and directed bench for secure_key_reader against a transaction-level reference model.
// Latency: model advances on each rising edge; DUT outputs are compared on the falling edge.
// Backpressure: the responder withholds, errors or spuriously drives acks to exercise stalls and timeouts.
module tb_secure_key_reader;

    localparam int KW = 128;
    localparam int WW = 32;
    localparam int TO = 16;
    localparam int NW = KW / WW;

    localparam int P_IDLE = 0;
    localparam int P_REQ  = 1;
    localparam int P_GAP  = 2;
    localparam int P_DONE = 3;
    localparam int P_ERR  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fs  = 1'b0;
    logic          kc  = 1'b0;
    logic          ack = 1'b0;
    logic          err = 1'b0;
    logic [WW-1:0] dat = '0;

    logic          rd_req;
    logic [1:0]    rd_addr;
    logic [KW-1:0] key_out;
    logic          key_valid;
    logic          busy;
    logic          fetch_err;

    secure_key_reader #(.KEY_W(KW), .WORD_W(WW), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_start_i(fs),
        .key_clear_i  (kc),
        .rd_req_o     (rd_req),
        .rd_addr_o    (rd_addr),
        .rd_ack_i     (ack),
        .rd_data_i    (dat),
        .rd_err_i     (err),
        .key_out_o    (key_out),
        .key_valid_o  (key_valid),
        .busy_o       (busy),
        .fetch_err_o  (fetch_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: where the fetch is, which word is next, how long it has waited, words gathered.
    int            m_ph;
    int            m_idx;
    int            m_wait;
    logic [WW-1:0] m_w [NW];

    function automatic logic [KW-1:0] m_key();
        logic [KW-1:0] k;
        k = '0;
        for (int i = 0; i < NW; i++) k[i*WW +: WW] = m_w[i];
        return k;
    endfunction

    task automatic m_wipe();
        for (int i = 0; i < NW; i++) m_w[i] = '0;
    endtask

    task automatic m_reset();
        m_ph = P_IDLE; m_idx = 0; m_wait = 0; m_wipe();
    endtask

    task automatic m_step();
        if (kc) begin
            m_reset();
        end else if (fs && m_ph != P_REQ && m_ph != P_GAP) begin
            m_ph = P_REQ; m_idx = 0; m_wait = 0; m_wipe();
        end else if (m_ph == P_REQ) begin
            if (err) begin
                m_ph = P_ERR; m_wipe();
            end else if (ack) begin
                m_w[m_idx] = dat;
                if (m_idx == NW - 1) m_ph = P_DONE;
                else begin m_idx++; m_ph = P_GAP; end
            end else begin
                m_wait++;
                if (m_wait == TO) begin m_ph = P_ERR; m_wipe(); end
            end
        end else if (m_ph == P_GAP) begin
            m_ph = P_REQ; m_wait = 0;
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".rd_req"},    128'(rd_req),    128'(m_ph == P_REQ));
        chk({ctx, ".rd_addr"},   128'(rd_addr),   (m_ph == P_REQ) ? 128'(m_idx) : 128'(0));
        chk({ctx, ".key_valid"}, 128'(key_valid), 128'(m_ph == P_DONE));
        chk({ctx, ".key_out"},   key_out,         (m_ph == P_DONE) ? m_key() : 128'(0));
        chk({ctx, ".busy"},      128'(busy),      128'(m_ph == P_REQ || m_ph == P_GAP));
        chk({ctx, ".fetch_err"}, 128'(fetch_err), 128'(m_ph == P_ERR));
    endtask

    // Drive inputs at the falling edge, advance model at the rising edge, compare at the next falling edge.
    task automatic cycle(input string ctx, input logic f, input logic c, input logic a,
                         input logic e, input logic [WW-1:0] d);
        fs = f; kc = c; ack = a; err = e; dat = d;
        @(posedge clk);
        m_step();
        @(negedge clk);
        check_all(ctx);
    endtask

    logic [WW-1:0] tw [NW];
    localparam logic [KW-1:0] GOLD = 128'h44444444_33333333_22222222_11111111;

    task automatic fetch_ok(input string ctx);
        cycle(ctx, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        repeat (10) cycle(ctx, 1'b0, 1'b0, m_ph == P_REQ, 1'b0, (m_ph == P_REQ) ? tw[m_idx] : '0);
    endtask

    initial begin
        int n, kv_at, cnt;
        logic [8:0] mask;
        tw[0] = 32'h11111111; tw[1] = 32'h22222222; tw[2] = 32'h33333333; tw[3] = 32'h44444444;
        m_reset();

        // Reset state
        #2 check_all("reset");
        @(negedge clk); rst = 1'b0;

        // 1: immediate acks, latency and gap pattern
        cycle("t1", 1'b1, 1'b0, 1'b0, 1'b0, '0);
        n = 1; mask = '0; kv_at = 0;
        if (rd_req) mask[1] = 1'b1;
        repeat (10) begin
            cycle("t1", 1'b0, 1'b0, m_ph == P_REQ, 1'b0, (m_ph == P_REQ) ? tw[m_idx] : '0);
            n++;
            if (n <= 8 && rd_req) mask[n] = 1'b1;
            if (key_valid && kv_at == 0) kv_at = n;
        end
        chk("t1.latency", 128'(kv_at), 128'(8));
        chk("t1.req_cycles", 128'(mask), 128'(9'h0AA));
        chk("t1.key", key_out, GOLD);

        // 2: word 2 never acked -> timeout
        cycle("t2", 1'b1, 1'b0, 1'b0, 1'b0, '0);
        cnt = 0;
        repeat (28) begin
            cycle("t2", 1'b0, 1'b0, m_ph == P_REQ && m_idx < 2, 1'b0, tw[m_idx]);
            if (rd_req && rd_addr == 2'd2) cnt++;
        end
        chk("t2.req_len", 128'(cnt), 128'(TO));
        chk("t2.fetch_err", 128'(fetch_err), 128'(1));
        chk("t2.key_out", key_out, 128'(0));

        // 3: ack and err together on word 1
        cycle("t3", 1'b1, 1'b0, 1'b0, 1'b0, '0);
        repeat (8) cycle("t3", 1'b0, 1'b0, m_ph == P_REQ, m_ph == P_REQ && m_idx == 1,
                         (m_idx == 1) ? 32'hDEADBEEF : tw[m_idx]);
        chk("t3.fetch_err", 128'(fetch_err), 128'(1));
        chk("t3.key_out", key_out, 128'(0));

        // 4: clear with simultaneous start from DONE
        fetch_ok("t4");
        chk("t4.held", key_out, GOLD);
        cycle("t4", 1'b1, 1'b1, 1'b0, 1'b0, '0);
        chk("t4.key_valid", 128'(key_valid), 128'(0));
        chk("t4.key_out", key_out, 128'(0));
        cycle("t4", 1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk("t4.rd_req", 128'(rd_req), 128'(0));

        // 5: async reset mid-fetch at word 2
        cycle("t5", 1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 20; i++) begin
            if (m_ph == P_REQ && m_idx == 2) break;
            cycle("t5", 1'b0, 1'b0, m_ph == P_REQ, 1'b0, tw[m_idx]);
        end
        chk("t5.pre_req", 128'(rd_req), 128'(1));
        fs = 1'b0; kc = 1'b0; ack = 1'b0; err = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("t5.arst.rd_req", 128'(rd_req), 128'(0));
        chk("t5.arst.rd_addr", 128'(rd_addr), 128'(0));
        chk("t5.arst.busy", 128'(busy), 128'(0));
        chk("t5.arst.key", key_out, 128'(0));
        m_reset();
        @(negedge clk);
        check_all("t5.rst");
        rst = 1'b0;
        fetch_ok("t5");
        chk("t5.key", key_out, GOLD);

        // 6: stray responses in IDLE and GAP
        cycle("t6", 1'b0, 1'b1, 1'b0, 1'b0, '0);
        repeat (4) cycle("t6", 1'b0, 1'b0, 1'b1, 1'b0, $urandom);
        cycle("t6", 1'b1, 1'b0, 1'b1, 1'b0, $urandom);
        repeat (10) cycle("t6", 1'b0, 1'b0, 1'b1, m_ph == P_GAP,
                          (m_ph == P_REQ) ? tw[m_idx] : $urandom);
        chk("t6.key", key_out, GOLD);

        // Random traffic
        repeat (1500) begin
            cycle("rnd", $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0,
                  $urandom_range(0, 1) == 0, $urandom_range(0, 24) == 0, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
